// File: rtl/apb_master_ctrl_if.sv
// rtl/apb_master_ctrl_if.sv - command/response port and two-slave APB bus of apb_master_ctrl
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL1;
    logic              PSEL2;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA1;
    logic [DATA_W-1:0] PRDATA2;
    logic              PREADY1;
    logic              PREADY2;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PRDATA1, PRDATA2, PREADY1, PREADY2,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PRDATA1, PRDATA2, PREADY1, PREADY2,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB requester for a two-slave segment; APB_TIMEOUT_EN adds an ACCESS timeout abort
module apb_master_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_master_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    state_t            next_state;
    logic              sel_hi;
    logic              pready_sel;
    logic [DATA_W-1:0] prdata_sel;
    logic              done;
    logic              abort;

    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 1");
    end

    // PADDR is held for the whole transfer, so its MSB is a stable slave select
    assign sel_hi        = bus.PADDR[ADDR_W-1];
    assign pready_sel    = sel_hi ? bus.PREADY2 : bus.PREADY1;
    assign prdata_sel    = sel_hi ? bus.PRDATA2 : bus.PRDATA1;
    assign done          = (state == ACCESS) && pready_sel;
    assign bus.req_ready = (state == IDLE);

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !pready_sel) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign abort = (state == ACCESS) && !pready_sel && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.req_valid) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (done || abort) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bus.PSEL1     <= 1'b0;
            bus.PSEL2     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.PWRITE <= bus.req_write;
                        bus.PADDR  <= bus.req_addr;
                        bus.PWDATA <= bus.req_wdata;
                        bus.PSEL1  <= ~bus.req_addr[ADDR_W-1];
                        bus.PSEL2  <= bus.req_addr[ADDR_W-1];
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (done || abort) begin
                        bus.PSEL1     <= 1'b0;
                        bus.PSEL2     <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= abort;
                        bus.rsp_rdata <= (abort || bus.PWRITE) ? '0 : prdata_sel;
                    end
                end
                default: begin
                    bus.PSEL1   <= 1'b0;
                    bus.PSEL2   <= 1'b0;
                    bus.PENABLE <= 1'b0;
                end
            endcase
        end
    end
endmodule
